// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle of pipeline-register addresses, write enables and
//                memory handshake seen by the hazard controller, together with
//                the forwarding selects, stall/flush controls and perf/status
//                outputs it returns. The master side is the pipeline datapath;
//                the slave side is the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int PERF_W = 16
) ();
    // Register addresses per stage
    logic [3:0]        RA1D;
    logic [3:0]        RA2D;
    logic [3:0]        RA1E;
    logic [3:0]        RA2E;
    logic [3:0]        WA3E;
    logic [3:0]        WA3M;
    logic [3:0]        WA3W;

    // Pipeline status
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MemtoRegE;
    logic              BranchTakenE;
    logic              MemReqM;
    logic              MemReadyM;

    // Controller results
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushW;
    logic [PERF_W-1:0] StallCount;
    logic              MemTimeout;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  StallCount, MemTimeout
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output StallCount, MemTimeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard unit for a 5-stage pipeline. Combinational operand
//                forwarding, load-use stall, taken-branch flush (two cycles)
//                and data-memory wait stall, with a saturating stall-cycle
//                counter. Define HAZ_MEMWAIT_TIMEOUT_EN to add a memory-wait
//                timeout that forces the pipeline out of MEMWAIT and raises a
//                sticky MemTimeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PERF_W         = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BRFLUSH = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [PERF_W-1:0] c_STALL_MAX = '1;
    localparam logic [PERF_W-1:0] c_STALL_ONE = PERF_W'(1);

    // Timeout limit must fit the 8-bit wait counter
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
            $error("pipe_hazard_ctrl: TIMEOUT_CYCLES must be 1..255");
        end
    endgenerate

    state_t            r_state;
    state_t            w_nextState;
    logic [PERF_W-1:0] r_stallCount;
    logic              w_memMiss;
    logic              w_loadUse;
    logic              w_stallF;
    logic              w_stallD;
    logic              w_stallE;
    logic              w_stallM;
    logic              w_flushD;
    logic              w_flushE;
    logic              w_flushW;

    assign w_memMiss = hz.MemReqM & ~hz.MemReadyM;
    assign w_loadUse = hz.MemtoRegE & ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));

`ifdef HAZ_MEMWAIT_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_toCount;
    logic       r_memTimeout;

    // Wait counter restarts on MEMWAIT entry and counts until the limit; the
    // flag is set on the edge that reaches the limit so it is visible in the
    // very cycle the stalls are released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCount    <= 8'd0;
            r_memTimeout <= 1'b0;
        end else if (r_state == RUN && w_memMiss) begin
            r_toCount    <= 8'd0;
        end else if (r_state == MEMWAIT && !hz.MemReadyM && r_toCount != c_TIMEOUT) begin
            r_toCount    <= r_toCount + 8'd1;
            if (r_toCount + 8'd1 == c_TIMEOUT) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    assign hz.MemTimeout = r_memTimeout;
`else
    assign hz.MemTimeout = 1'b0;
`endif

    // Operand forwarding: the younger Memory-stage result wins over Writeback
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.WA3M == hz.RA1E) begin
            hz.ForwardAE = 2'b10;
        end else if (hz.RegWriteW && hz.WA3W == hz.RA1E) begin
            hz.ForwardAE = 2'b01;
        end
        if (hz.RegWriteM && hz.WA3M == hz.RA2E) begin
            hz.ForwardBE = 2'b10;
        end else if (hz.RegWriteW && hz.WA3W == hz.RA2E) begin
            hz.ForwardBE = 2'b01;
        end
    end

    // Control state register; reset aborts any branch flush or memory wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and stall/flush decode; priority is miss, branch, load-use
    always_comb begin
        w_nextState = r_state;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_stallE    = 1'b0;
        w_stallM    = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        w_flushW    = 1'b0;
        case (r_state)
            RUN: begin
                if (w_memMiss) begin
                    w_stallF    = 1'b1;
                    w_stallD    = 1'b1;
                    w_stallE    = 1'b1;
                    w_stallM    = 1'b1;
                    w_flushW    = 1'b1;
                    w_nextState = MEMWAIT;
                end else if (hz.BranchTakenE) begin
                    w_flushD    = 1'b1;
                    w_flushE    = 1'b1;
                    w_nextState = BRFLUSH;
                end else if (w_loadUse) begin
                    w_stallF    = 1'b1;
                    w_stallD    = 1'b1;
                    w_flushE    = 1'b1;
                end
            end
            BRFLUSH: begin
                // Execute holds a bubble, so a branch here is stale; a pending
                // miss is picked up from RUN on the following cycle.
                w_flushD    = 1'b1;
                w_nextState = RUN;
            end
            MEMWAIT: begin
                if (hz.MemReadyM) begin
                    w_nextState = RUN;
`ifdef HAZ_MEMWAIT_TIMEOUT_EN
                end else if (r_toCount == c_TIMEOUT) begin
                    w_nextState = RUN;
`endif
                end else begin
                    w_stallF    = 1'b1;
                    w_stallD    = 1'b1;
                    w_stallE    = 1'b1;
                    w_stallM    = 1'b1;
                    w_flushW    = 1'b1;
                end
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // Controls are forced low while reset is held, independent of the inputs
    assign hz.StallF = rst_n & w_stallF;
    assign hz.StallD = rst_n & w_stallD;
    assign hz.StallE = rst_n & w_stallE;
    assign hz.StallM = rst_n & w_stallM;
    assign hz.FlushD = rst_n & w_flushD;
    assign hz.FlushE = rst_n & w_flushE;
    assign hz.FlushW = rst_n & w_flushW;

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
        end else if (hz.StallF && r_stallCount != c_STALL_MAX) begin
            r_stallCount <= r_stallCount + c_STALL_ONE;
        end
    end

    assign hz.StallCount = r_stallCount;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. Expected control
//                vectors are queued as stimulus is applied and compared on the
//                falling edge. A second instance with a 3-bit counter covers
//                counter saturation. Timeout section active when
//                HAZ_MEMWAIT_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
`ifdef HAZ_MEMWAIT_TIMEOUT_EN
    localparam int c_TO = 8;
`else
    localparam int c_TO = 255;
`endif
    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] c_NONE = 7'b0000_000;
    localparam logic [6:0] c_LU   = 7'b1100_010;
    localparam logic [6:0] c_BR   = 7'b0000_110;
    localparam logic [6:0] c_BRF  = 7'b0000_100;
    localparam logic [6:0] c_MISS = 7'b1111_001;

    typedef struct {
        logic [6:0]  ctrl;
        logic [15:0] cnt;
        logic        to;
        string       tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nCompared   = 0;
    int   nMismatched = 0;
    logic [15:0] modelCnt = 16'd0;
    logic        modelTo  = 1'b0;
    exp_t        sbq[$];
    exp_t        sbHead;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.PERF_W(16)) hz  ();
    pipe_hazard_ctrl_if #(.PERF_W(3))  hzs ();

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(c_TO), .PERF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(255), .PERF_W(3)) dutSat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hzs)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        nCompared++;
        if (obs !== expVal) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
        end
    endtask

    function automatic logic [6:0] obsCtrl();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
    endfunction

    task automatic setIn(input logic req, input logic rdy, input logic br, input logic lu);
        hz.MemReqM      = req;
        hz.MemReadyM    = rdy;
        hz.BranchTakenE = br;
        hz.MemtoRegE    = lu;
        hz.WA3E         = 4'd5;
        hz.RA1D         = 4'd0;
        hz.RA2D         = lu ? 4'd5 : 4'd0;
    endtask

    // One pipeline cycle: drive after the rising edge, queue the expectation
    task automatic cycle(input logic req, input logic rdy, input logic br, input logic lu,
                         input logic [6:0] ctrl, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        setIn(req, rdy, br, lu);
        e.ctrl = ctrl;
        e.cnt  = modelCnt;
        e.to   = modelTo;
        e.tag  = tag;
        sbq.push_back(e);
        if (ctrl[6]) modelCnt = modelCnt + 16'd1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            sbHead = sbq.pop_front();
            checkVal({sbHead.tag, "_ctrl"}, 32'(obsCtrl()), 32'(sbHead.ctrl));
            checkVal({sbHead.tag, "_cnt"}, 32'(hz.StallCount), 32'(sbHead.cnt));
            checkVal({sbHead.tag, "_to"}, 32'(hz.MemTimeout), 32'(sbHead.to));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hz.RA1D = 4'd0; hz.RA2D = 4'd0; hz.RA1E = 4'd0; hz.RA2E = 4'd0;
        hz.WA3E = 4'd0; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.MemtoRegE = 1'b0;
        hz.BranchTakenE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
        hzs.RA1D = 4'd0; hzs.RA2D = 4'd0; hzs.RA1E = 4'd1; hzs.RA2E = 4'd1;
        hzs.WA3E = 4'd0; hzs.WA3M = 4'd0; hzs.WA3W = 4'd0;
        hzs.RegWriteM = 1'b0; hzs.RegWriteW = 1'b0; hzs.MemtoRegE = 1'b0;
        hzs.BranchTakenE = 1'b0; hzs.MemReqM = 1'b0; hzs.MemReadyM = 1'b0;

        // Reset with every hazard present: controls low, forwarding live
        setIn(1'b1, 1'b0, 1'b1, 1'b1);
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd2; hz.RA1E = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_ctrl", 32'(obsCtrl()), 32'(c_NONE));
        checkVal("rst_cnt", 32'(hz.StallCount), 32'd0);
        checkVal("rst_to", 32'(hz.MemTimeout), 32'd0);
        checkVal("rst_fwdA", 32'(hz.ForwardAE), 32'd2);
        setIn(1'b0, 1'b0, 1'b0, 1'b0);
        hz.RegWriteM = 1'b0; hz.WA3M = 4'd0; hz.RA1E = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding priority and R15
        #1;
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd3; hz.RegWriteW = 1'b1; hz.WA3W = 4'd3; hz.RA1E = 4'd3;
        #1; checkVal("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
        hz.RegWriteM = 1'b0;
        #1; checkVal("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
        hz.RA2E = 4'd3;
        #1; checkVal("fwdB_wb", 32'(hz.ForwardBE), 32'd1);
        hz.WA3W = 4'd9;
        #1; checkVal("fwdB_none", 32'(hz.ForwardBE), 32'd0);
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd15; hz.RA1E = 4'd15; hz.RA2E = 4'd14;
        #1; checkVal("fwdA_r15", 32'(hz.ForwardAE), 32'd2);
        checkVal("fwdB_r15", 32'(hz.ForwardBE), 32'd0);
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.WA3M = 4'd0; hz.WA3W = 4'd0; hz.RA1E = 4'd0; hz.RA2E = 4'd0;

        //     req   rdy   br    lu
        cycle(1'b0, 1'b0, 1'b0, 1'b1, c_LU,   "loaduse");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "lu_after");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, c_BR,   "br_n");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_BRF,  "br_n1");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "br_n2");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, c_BR,   "br_over_lu");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, c_BRF,  "br_ignored");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "br_done");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "memwait");
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, c_NONE, "mem_ready");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "mem_after");
        cycle(1'b1, 1'b0, 1'b1, 1'b1, c_MISS, "prio_miss");
        cycle(1'b1, 1'b0, 1'b1, 1'b1, c_MISS, "prio_wait");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, c_NONE, "prio_ready");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, c_BR,   "prio_br");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_BRF,  "prio_brf");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, c_BR,   "defer_br");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_BRF,  "defer_brf");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "defer_miss");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, c_NONE, "defer_ready");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "idle");

`ifdef HAZ_MEMWAIT_TIMEOUT_EN
        // One RUN miss cycle plus eight MEMWAIT cycles, then forced release
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "to_wait");
        end
        modelTo = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_NONE, "to_release");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "to_rewait");
`endif

        // Reset in the middle of a memory wait
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "pre_rst_miss");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, c_MISS, "pre_rst_wait");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midrst_ctrl", 32'(obsCtrl()), 32'(c_NONE));
        checkVal("midrst_cnt", 32'(hz.StallCount), 32'd0);
        checkVal("midrst_to", 32'(hz.MemTimeout), 32'd0);
        modelCnt = 16'd0;
        modelTo  = 1'b0;
        setIn(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, c_BR,   "postrst_br");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_BRF,  "postrst_brf");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, c_NONE, "postrst_idle");

        // Counter saturation on the 3-bit instance
        @(posedge clk);
        #1;
        hzs.MemReqM = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkVal("sat_cnt6", 32'(hzs.StallCount), 32'd6);
        repeat (4) @(posedge clk);
        #1;
        checkVal("sat_cnt7", 32'(hzs.StallCount), 32'd7);
        checkVal("sat_stall", 32'(hzs.StallF), 32'd1);
        hzs.MemReqM = 1'b0;

        @(posedge clk);
        @(negedge clk);
        checkVal("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, memory-wait cycles before timeout (1..255).
REQ-002 Parameter: PERF_W, default 16, width of stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 RA1D, RA2D  input  4 each  source registers of the instruction in Decode.
REQ-006 RA1E, RA2E  input  4 each  source registers of the instruction in Execute.
REQ-007 WA3E, WA3M, WA3W  input  4 each  destination registers in Execute, Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  input  1 each  register write pending in Memory and Writeback.
REQ-009 MemtoRegE  input  1  the instruction in Execute is a load.
REQ-010 BranchTakenE  input  1  taken branch resolved in Execute (branch AND condExE).
REQ-011 MemReqM, MemReadyM  input  1 each  data-memory request and ready handshake in Memory.
REQ-012 ForwardAE, ForwardBE  output  2 each  operand mux select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-013 StallF, StallD, StallE, StallM  output  1 each  hold the pipeline register of that stage.
REQ-014 FlushD, FlushE, FlushW  output  1 each  bubble the pipeline register of that stage.
REQ-015 StallCount  output  PERF_W  saturating count of cycles with StallF=1.
REQ-016 MemTimeout  output  1  sticky memory-timeout flag.

Function
REQ-017 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM and WA3M==RA1E; else 01 if RegWriteW and WA3W==RA1E; else 00. ForwardBE SHALL use RA2E in place of RA1E. R15 SHALL receive no special treatment.
REQ-018 The FSM SHALL have three states. RUN is the normal state. BRFLUSH is a one-cycle follow-up flush after a taken branch. MEMWAIT is a memory stall.
REQ-019 In RUN, a memory miss (MemReqM=1, MemReadyM=0) SHALL assert StallF, StallD, StallE, StallM and FlushW in the same cycle and move the FSM to MEMWAIT.
REQ-020 In MEMWAIT, the same stall and flush outputs SHALL be held every cycle while MemReadyM=0. On the first cycle with MemReadyM=1, all outputs SHALL deassert and the FSM SHALL return to RUN.
REQ-021 In RUN with no memory miss, BranchTakenE=1 SHALL assert FlushD and FlushE in that cycle and move the FSM to BRFLUSH.
REQ-022 BRFLUSH SHALL assert FlushD only, then return to RUN unconditionally. A BranchTakenE seen in BRFLUSH SHALL be ignored, because Execute holds a bubble.
REQ-023 In RUN with no miss and no taken branch, a load-use hazard (MemtoRegE and WA3E equal to RA1D or RA2D) SHALL assert StallF, StallD and FlushE for that cycle only. The FSM SHALL stay in RUN.
REQ-024 Priority SHALL be memory miss, then taken branch, then load-use. When a branch and a load-use hazard coincide, the outputs SHALL be those of the branch only.
REQ-025 A memory miss seen in BRFLUSH SHALL be deferred: BRFLUSH completes, and the miss is taken in RUN on the next cycle.
REQ-026 StallCount SHALL increment by 1 on each rising edge where StallF=1. It SHALL stay at 2^PERF_W-1 once it reaches that value and SHALL NOT wrap.
REQ-027 All outputs SHALL be valid in the same cycle as their inputs (zero latency). Only the state, the counters and MemTimeout are registered.

Reset
REQ-028 When rst_n=0, the FSM SHALL enter RUN asynchronously, and StallCount, the timeout counter and MemTimeout SHALL clear to 0.
REQ-029 During reset, all stall and flush outputs SHALL be 0. Forward outputs SHALL follow REQ-017.
REQ-030 Reset asserted in MEMWAIT or BRFLUSH SHALL abort the sequence. The first cycle after reset SHALL be evaluated from RUN.

Configuration
REQ-031 Macro HAZ_MEMWAIT_TIMEOUT_EN, when defined, SHALL add an 8-bit timeout counter:
- cleared on entry to MEMWAIT;
- incremented each cycle spent in MEMWAIT;
- on reaching TIMEOUT_CYCLES: set MemTimeout, force return to RUN, release all stalls.
MemTimeout stays 1 until reset.
REQ-032 Without HAZ_MEMWAIT_TIMEOUT_EN, MEMWAIT SHALL wait indefinitely for MemReadyM. MemTimeout SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-033 Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01.
REQ-034 Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; StallCount +1.
REQ-035 Branch: BranchTakenE=1 for one cycle -> FlushD=FlushE=1 in cycle N, then FlushD=1 and FlushE=0 in cycle N+1, then all 0.
REQ-036 Memory wait: MemReqM=1 with MemReadyM=0 for 4 cycles, then 1 -> StallF/D/E/M and FlushW high for 4 cycles, low on the ready cycle; StallCount=4.
REQ-037 Priority: MemReqM=1, MemReadyM=0, BranchTakenE=1 and a load-use hazard in the same cycle -> stall outputs only, no FlushD. The branch flush is taken after MemReadyM=1 if BranchTakenE is still held.
REQ-038 Timeout (with HAZ_MEMWAIT_TIMEOUT_EN, TIMEOUT_CYCLES=8): MemReadyM held 0 -> stalls release after 8 MEMWAIT cycles and MemTimeout=1 stays set. Pulsing rst_n low mid-MEMWAIT -> all outputs 0 immediately and MemTimeout=0.
